// File: rtl/cavlc_mb_scheduler.sv
// cavlc_mb_scheduler
//
// Walks one 16x16 luma macroblock through a single-slot CAVLC coefficient
// counter, one 4x4 block at a time. Blocks are issued in 8x8-quadrant / Z order.
// For each block the scheduler drives the top-left pixel coordinate and the nC
// context, then captures the block's total-coefficient count. nC is predicted
// from the left (nA) and upper (nB) neighbour counts. Those counts come from
// the current MB, from the previous MB's right column, or from a line buffer
// that holds the bottom row of the MB row above.
//
// Optional feature macro: CAVLC_SCHED_STAT_EN adds per-MB statistics outputs.
//
// Parameters
//   MB_W_MAX        maximum picture width in MBs (line buffer = 4*MB_W_MAX x 5b)
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   mb_start        one-cycle MB request, sampled only in IDLE
//   mb_x, mb_y      MB column / row, sampled with mb_start
//   pic_w_mb        picture width in MBs (static per frame)
//   mb_busy         high while an MB is in flight (through MB_DONE)
//   mb_done         one-cycle pulse after block 15's count is captured
//   blk_valid       one-cycle issue pulse to the counter
//   blk_idx         current block index 0..15 (coefficient buffer select)
//   topleft_x/y     top-left pixel coordinate of the current block
//   nc              nC context of the current block
//   cnt_ready       counter idle / released by the encoder
//   cnt_valid       counter result valid
//   total_coeff_cnt counter result 0..16
//   nz_blk_cnt      [STAT] blocks with a nonzero count in the last MB
//   mb_cycles       [STAT] saturating cycle count from mb_start to mb_done

module cavlc_mb_scheduler #(
  parameter int MB_W_MAX = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mb_start,
  input  logic [6:0] mb_x,
  input  logic [6:0] mb_y,
  input  logic [6:0] pic_w_mb,
  output logic       mb_busy,
  output logic       mb_done,
  output logic       blk_valid,
  output logic [3:0] blk_idx,
  output logic [9:0] topleft_x,
  output logic [9:0] topleft_y,
  output logic [4:0] nc,
  input  logic       cnt_ready,
  input  logic       cnt_valid,
  input  logic [4:0] total_coeff_cnt
`ifdef CAVLC_SCHED_STAT_EN
  ,
  output logic [4:0]  nz_blk_cnt,
  output logic [15:0] mb_cycles
`endif
);

  localparam int TOP_DEPTH = 4 * MB_W_MAX;
  localparam int TOP_AW    = (TOP_DEPTH > 1) ? $clog2(TOP_DEPTH) : 1;
  // mb_x is 7 bits, so any limit above 128 behaves like 128.
  localparam logic [7:0] MB_W_LIM = 8'((MB_W_MAX > 128) ? 128 : MB_W_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CNT,
    S_WAIT_REL,
    S_MB_DONE
  } state_t;

  state_t state, state_nxt;

  logic [6:0] mb_x_r, mb_y_r;
  logic [4:0] cur      [16];        // current MB counts, index {by, bx}
  logic [4:0] left     [4];         // previous MB column 3, index by
  logic [4:0] top_mem  [TOP_DEPTH]; // row 3 of the MB row above

  // Block geometry of the block currently issued (for the capture write).
  logic [1:0] cur_bx, cur_by;
  assign cur_bx = {blk_idx[2], blk_idx[0]};
  assign cur_by = {blk_idx[3], blk_idx[1]};

  logic start_ok, rel_ok, load_blk;
  assign start_ok = (state == S_IDLE) && mb_start;
  // A simultaneous cnt_valid wins over cnt_ready, so release needs !cnt_valid.
  assign rel_ok   = (state == S_WAIT_REL) && cnt_ready && !cnt_valid;
  assign load_blk = start_ok || (rel_ok && (blk_idx != 4'd15));

  // ---------------------------------------------------------------------------
  // FSM next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_nxt = state;
    blk_valid = 1'b0;
    mb_done   = 1'b0;
    mb_busy   = (state != S_IDLE);
    unique case (state)
      S_IDLE:     if (mb_start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (cnt_ready) begin
          blk_valid = 1'b1;
          state_nxt = S_WAIT_CNT;
        end
      end
      S_WAIT_CNT: if (cnt_valid) state_nxt = S_WAIT_REL;
      S_WAIT_REL: begin
        if (cnt_ready && !cnt_valid)
          state_nxt = (blk_idx == 4'd15) ? S_MB_DONE : S_ISSUE;
      end
      S_MB_DONE: begin
        mb_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Context of the block about to be issued: computed one edge ahead so that
  // nc/topleft are registered on ISSUE entry. The count of the block just
  // finished is already in cur, because capture precedes the WAIT_REL exit.
  // ---------------------------------------------------------------------------
  logic [3:0]        nxt_idx;
  logic [6:0]        ctx_x, ctx_y;
  logic [1:0]        nbx, nby, nbx_m1, nby_m1;
  logic              a_ok, b_ok, top_in_range;
  logic [4:0]        a_val, b_val, top_rd, nc_nxt;
  logic [5:0]        ab_sum;
  logic [TOP_AW-1:0] top_rd_addr;

  always_comb begin
    nxt_idx     = start_ok ? 4'd0 : (blk_idx + 4'd1);
    ctx_x       = start_ok ? mb_x : mb_x_r;
    ctx_y       = start_ok ? mb_y : mb_y_r;
    nbx         = {nxt_idx[2], nxt_idx[0]};
    nby         = {nxt_idx[3], nxt_idx[1]};
    nbx_m1      = nbx - 2'd1;
    nby_m1      = nby - 2'd1;
    top_in_range = ({1'b0, ctx_x} < MB_W_LIM);
    top_rd_addr = TOP_AW'({ctx_x, nbx});
    top_rd      = top_in_range ? top_mem[top_rd_addr] : 5'd0;

    a_ok  = (nbx != 2'd0) || (ctx_x != 7'd0);
    a_val = (nbx != 2'd0) ? cur[{nby, nbx_m1}] : left[nby];
    b_ok  = (nby != 2'd0) || (ctx_y != 7'd0);
    b_val = (nby != 2'd0) ? cur[{nby_m1, nbx}] : top_rd;

    ab_sum = {1'b0, a_val} + {1'b0, b_val} + 6'd1;
    if (a_ok && b_ok) nc_nxt = ab_sum[5:1];
    else if (a_ok)    nc_nxt = a_val;
    else if (b_ok)    nc_nxt = b_val;
    else              nc_nxt = 5'd0;
  end

  // ---------------------------------------------------------------------------
  // State, block registers and current-MB count storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      blk_idx   <= 4'd0;
      topleft_x <= 10'd0;
      topleft_y <= 10'd0;
      nc        <= 5'd0;
      mb_x_r    <= 7'd0;
      mb_y_r    <= 7'd0;
      for (int i = 0; i < 16; i++) cur[i] <= 5'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
      if (start_ok) begin
        mb_x_r <= mb_x;
        mb_y_r <= mb_y;
      end
      if (load_blk) begin
        blk_idx   <= nxt_idx;
        nc        <= nc_nxt;
        topleft_x <= 10'({ctx_x, 4'b0000}) + 10'({nbx, 2'b00});
        topleft_y <= 10'({ctx_y, 4'b0000}) + 10'({nby, 2'b00});
      end
      if ((state == S_WAIT_CNT) && cnt_valid)
        cur[{cur_by, cur_bx}] <= total_coeff_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Neighbour storage carried across MBs. Writes past the picture width or the
  // buffer size are dropped; the MB itself still processes normally.
  // ---------------------------------------------------------------------------
  logic top_wr_en;
  assign top_wr_en = (mb_x_r < pic_w_mb) && ({1'b0, mb_x_r} < MB_W_LIM);

  // NOTE: left and the line buffer are deliberately not reset; availability is
  // decided purely by mb_x/mb_y, so stale contents are never consumed.
  always_ff @(posedge clk) begin
    if (state == S_MB_DONE) begin
      for (int r = 0; r < 4; r++) left[r] <= cur[{2'(r), 2'd3}];
      if (top_wr_en)
        for (int c = 0; c < 4; c++) top_mem[TOP_AW'({mb_x_r, 2'(c)})] <= cur[{2'd3, 2'(c)}];
    end
  end

`ifdef CAVLC_SCHED_STAT_EN
  logic [4:0]  nz_run;
  logic [15:0] cyc_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_run     <= 5'd0;
      cyc_run    <= 16'd0;
      nz_blk_cnt <= 5'd0;
      mb_cycles  <= 16'd0;
    end else begin
      if (start_ok) begin
        nz_run  <= 5'd0;
        cyc_run <= 16'd1;
      end else if (state != S_IDLE) begin
        if (cyc_run != 16'hFFFF) cyc_run <= cyc_run + 16'd1;
      end
      if ((state == S_WAIT_CNT) && cnt_valid && (total_coeff_cnt != 5'd0))
        nz_run <= nz_run + 5'd1;
      if (state == S_MB_DONE) begin
        nz_blk_cnt <= nz_run;
        mb_cycles  <= cyc_run;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cavlc_mb_scheduler.sv
// Self-checking bench for cavlc_mb_scheduler. A behavioural counter model
// answers each issue 18 cycles later; a reference nC model pushes expected
// per-block results to a scoreboard queue that a monitor pops on blk_valid.
`timescale 1ns/1ps
module tb_cavlc_mb_scheduler;

  localparam int MB_W_MAX = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mb_start = 1'b0;
  logic [6:0] mb_x = '0, mb_y = '0, pic_w_mb = 7'd2;
  logic       mb_busy, mb_done, blk_valid;
  logic [3:0] blk_idx;
  logic [9:0] topleft_x, topleft_y;
  logic [4:0] nc;
  logic       cnt_ready, cnt_valid;
  logic [4:0] total_coeff_cnt;
`ifdef CAVLC_SCHED_STAT_EN
  logic [4:0]  nz_blk_cnt;
  logic [15:0] mb_cycles;
`endif

  cavlc_mb_scheduler #(.MB_W_MAX(MB_W_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .mb_start(mb_start), .mb_x(mb_x), .mb_y(mb_y),
    .pic_w_mb(pic_w_mb), .mb_busy(mb_busy), .mb_done(mb_done),
    .blk_valid(blk_valid), .blk_idx(blk_idx), .topleft_x(topleft_x),
    .topleft_y(topleft_y), .nc(nc), .cnt_ready(cnt_ready), .cnt_valid(cnt_valid),
    .total_coeff_cnt(total_coeff_cnt)
`ifdef CAVLC_SCHED_STAT_EN
    , .nz_blk_cnt(nz_blk_cnt), .mb_cycles(mb_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int nc;
    int tx;
    int ty;
  } blk_exp_t;

  blk_exp_t   sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_issue  = 0;
  int         n_done   = 0;
  logic [4:0] cnt_tab [16];
  int         left_m [4];
  int         top_m [4*MB_W_MAX];
  int         pend_left [4];
  int         pend_top [4];
  int         pend_x;
  bit         pend_top_wr;
  int         obs_nc [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: expected nc/topleft for all 16 blocks of MB (x,y).
  function automatic void plan_mb(input int x, input int y);
    int c2d [4][4];
    int col, row, a, bv, e;
    bit ha, hb;
    blk_exp_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) c2d[r][c] = 0;
    for (int b = 0; b < 16; b++) begin
      col = ((b / 4) % 2) * 2 + (b % 2);
      row = (b / 8) * 2 + ((b / 2) % 2);
      ha  = (col > 0) || (x > 0);
      a   = (col > 0) ? c2d[row][col-1] : left_m[row];
      hb  = (row > 0) || (y > 0);
      bv  = (row > 0) ? c2d[row-1][col] : top_m[x*4+col];
      if (ha && hb) e = (a + bv + 1) / 2;
      else if (ha)  e = a;
      else if (hb)  e = bv;
      else          e = 0;
      t.idx = b;
      t.nc  = e;
      t.tx  = (x * 16 + col * 4) % 1024;
      t.ty  = (y * 16 + row * 4) % 1024;
      sb_q.push_back(t);
      c2d[row][col] = int'(cnt_tab[b]);
    end
    for (int r = 0; r < 4; r++) pend_left[r] = c2d[r][3];
    for (int c = 0; c < 4; c++) pend_top[c] = c2d[3][c];
    pend_x      = x;
    pend_top_wr = (x < int'(pic_w_mb)) && (x < MB_W_MAX);
  endfunction

  function automatic void commit_mb();
    for (int r = 0; r < 4; r++) left_m[r] = pend_left[r];
    if (pend_top_wr)
      for (int c = 0; c < 4; c++) top_m[pend_x*4+c] = pend_top[c];
  endfunction

  // Counter model: result 18 cycles after the issue pulse, then 2-cycle hold.
  initial begin
    cnt_ready       = 1'b1;
    cnt_valid       = 1'b0;
    total_coeff_cnt = 5'd0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && blk_valid === 1'b1) begin
        automatic int b = int'(blk_idx);
        @(posedge clk);
        #1 cnt_ready = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        cnt_valid       = 1'b1;
        total_coeff_cnt = cnt_tab[b];
        @(posedge clk);
        #1;
        cnt_valid       = 1'b0;
        total_coeff_cnt = 5'd0;
        repeat (2) @(posedge clk);
        #1 cnt_ready = 1'b1;
      end
    end
  end

  // Monitor: pop and compare on every issue pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mb_done === 1'b1) n_done++;
      if (blk_valid === 1'b1) begin
        n_issue++;
        check("sb_has_entry", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          automatic blk_exp_t e = sb_q.pop_front();
          check("blk_idx", blk_idx, e.idx);
          check("topleft_x", topleft_x, e.tx);
          check("topleft_y", topleft_y, e.ty);
          check("nc", nc, e.nc);
          obs_nc[blk_idx] = int'(nc);
        end
      end
    end
  end

  task automatic run_mb(input int x, input int y, input bit poke);
    int issue0, done0;
    bit got;
    plan_mb(x, y);
    issue0 = n_issue;
    done0  = n_done;
    @(negedge clk);
    mb_x     = 7'(x);
    mb_y     = 7'(y);
    mb_start = 1'b1;
    @(negedge clk);
    mb_start = 1'b0;
    check("busy_after_start", mb_busy, 1);
    got = 1'b0;
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 100) begin
        mb_x     = 7'(x + 1);
        mb_y     = 7'(y + 1);
        mb_start = 1'b1;
      end else begin
        mb_start = 1'b0;
      end
      if (mb_done === 1'b1) got = 1'b1;
    end
    check("mb_done_seen", got, 1);
    @(negedge clk);
    check("done_one_pulse", mb_done, 0);
    check("idle_after_done", mb_busy, 0);
    check("done_count", n_done - done0, 1);
    check("blocks_issued", n_issue - issue0, 16);
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
    commit_mb();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int i = 0; i < 16; i++) begin cnt_tab[i] = 5'd0; obs_nc[i] = 0; end
    for (int i = 0; i < 4; i++) left_m[i] = 0;
    for (int i = 0; i < 4*MB_W_MAX; i++) top_m[i] = 0;

    // Reset state
    #1;
    check("rst_blk_valid", blk_valid, 0);
    check("rst_mb_busy", mb_busy, 0);
    check("rst_mb_done", mb_done, 0);
    check("rst_blk_idx", blk_idx, 0);
    check("rst_nc", nc, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MB (0,0), all counts zero
    run_mb(0, 0, 1'b0);

    // MB (0,0), count = blk_idx
    for (int i = 0; i < 16; i++) cnt_tab[i] = 5'(i);
    run_mb(0, 0, 1'b0);
    check("mb00_blk3_nc", obs_nc[3], 2);
    check("mb00_blk1_nc", obs_nc[1], 0);

    // MB (1,0): left neighbour only
    run_mb(1, 0, 1'b0);
    check("mb10_blk0_nc", obs_nc[0], 5);

    // Row 1
    for (int i = 0; i < 16; i++) cnt_tab[i] = 5'((i * 3) % 17);
    run_mb(0, 1, 1'b0);
    run_mb(1, 1, 1'b1);  // mb_start pulsed mid-MB must be ignored
    check("mb11_blk0_nc", obs_nc[0], 13);

    // mb_x beyond picture width: top write suppressed; 4 nonzero blocks
    pic_w_mb = 7'd1;
    for (int i = 0; i < 16; i++) cnt_tab[i] = 5'd0;
    cnt_tab[2] = 5'd7; cnt_tab[5] = 5'd3; cnt_tab[9] = 5'd16; cnt_tab[14] = 5'd1;
    run_mb(1, 0, 1'b0);
`ifdef CAVLC_SCHED_STAT_EN
    check("stat_nz_blk_cnt", nz_blk_cnt, 4);
`endif
    pic_w_mb = 7'd2;
    for (int i = 0; i < 16; i++) cnt_tab[i] = 5'(i);
    run_mb(1, 1, 1'b0);
    check("suppressed_top_blk0_nc", obs_nc[0], 8);

    // Reset during block 7 WAIT_CNT
    plan_mb(0, 0);
    @(negedge clk);
    mb_x = 7'd0; mb_y = 7'd0; mb_start = 1'b1;
    got = 1'b0;
    for (int cyc = 0; cyc < 1000 && !got; cyc++) begin
      @(negedge clk);
      mb_start = 1'b0;
      if (blk_valid === 1'b1 && blk_idx == 4'd7) got = 1'b1;
    end
    check("reached_blk7", got, 1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_blk_valid", blk_valid, 0);
    check("midrst_mb_busy", mb_busy, 0);
    check("midrst_mb_done", mb_done, 0);
    check("midrst_blk_idx", blk_idx, 0);
    check("midrst_topleft_x", topleft_x, 0);
    check("midrst_topleft_y", topleft_y, 0);
    check("midrst_nc", nc, 0);
    sb_q.delete();
    got = 1'b0;
    for (int cyc = 0; cyc < 100 && !got; cyc++) begin
      @(negedge clk);
      if (cnt_ready === 1'b1) got = 1'b1;
    end
    check("counter_released", got, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_idle", mb_busy, 0);
    run_mb(0, 0, 1'b0);
    check("postrst_blk3_nc", obs_nc[3], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_mb_scheduler.md
# cavlc_mb_scheduler

Sequences one 16x16 luma macroblock through the single-slot CAVLC counter, one 4x4 block at a time. Issues the 16 blocks in H.264 8x8-quadrant/Z order and drives the per-block top-left pixel coordinates. Captures each block's total-coefficient count and computes the nC context (neighbour prediction) for every block. Sits between the quant/coefficient buffer and the CAVLC counter/encoder pair.

## Interface
- `MB_W_MAX`, default 120: maximum picture width in macroblocks; sizes the top-row line buffer to 4*MB_W_MAX x 5 bits.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mb_start` in 1: one-cycle request to process a macroblock; sampled only in IDLE.
- `mb_x` in 7: macroblock column; sampled with `mb_start`.
- `mb_y` in 7: macroblock row; sampled with `mb_start`.
- `pic_w_mb` in 7: picture width in MBs; static per frame, 1..MB_W_MAX.
- `mb_busy` out 1: high from the cycle after an accepted `mb_start` through MB_DONE.
- `mb_done` out 1: one-cycle pulse after block 15's count is captured.
- `blk_valid` out 1: one-cycle issue pulse to the counter's `valid`.
- `blk_idx` out 4: current block index 0..15; selects coefficients in the source buffer.
- `topleft_x` out 10: `mb_x*16 + bx*4`.
- `topleft_y` out 10: `mb_y*16 + by*4`.
- `nc` out 5: nC for the current block; valid from `blk_valid` until the next `blk_valid`.
- `cnt_ready` in 1: counter idle.
- `cnt_valid` in 1: counter results valid.
- `total_coeff_cnt` in 5: counter result, 0..16.

## Operation
- Block mapping:
  - `bx = {blk_idx[2], blk_idx[0]}`.
  - `by = {blk_idx[3], blk_idx[1]}`.
- Storage:
  - `cur[16]` holds the current MB's counts, indexed by (by,bx).
  - `left[4]` holds the previous MB's column 3.
  - `top[4*MB_W_MAX]` holds the MB row above, row 3.
- nC neighbours:
  - nA = `cur[by][bx-1]` if bx>0; else `left[by]` if mb_x>0; else unavailable.
  - nB = `cur[by-1][bx]` if by>0; else `top[mb_x*4+bx]` if mb_y>0; else unavailable.
- nC value:
  - Both available: nc = (nA+nB+1)>>1, computed in 6-bit arithmetic.
  - One available: nc = that one.
  - Neither available: nc = 0.
- States:
  - IDLE -> ISSUE on `mb_start`. Latch mb_x/mb_y, set blk_idx=0.
  - ISSUE: wait for `cnt_ready`. When it is high, assert `blk_valid` for exactly that one cycle with registered nc/topleft, then go to WAIT_CNT.
  - WAIT_CNT: on the first `cnt_valid` cycle, write `total_coeff_cnt` into `cur[by][bx]`, then go to WAIT_REL.
  - WAIT_REL: wait for `cnt_ready`=1, which indicates the encoder has released the counter. If blk_idx==15, go to MB_DONE. Otherwise increment blk_idx and go to ISSUE.
  - MB_DONE: copy cur column 3 into `left`, copy cur row 3 into `top[mb_x*4 .. mb_x*4+3]`, pulse `mb_done`, go to IDLE.
- Boundary behaviour:
  - `mb_start` outside IDLE is ignored.
  - `mb_x=0` makes `left` unused, not cleared.
  - `mb_y=0` makes `top` unused.
  - Line buffer and `left` are not reset; availability comes only from mb_x/mb_y.
  - `mb_x >= pic_w_mb` or `mb_x >= MB_W_MAX`: block still processes, top buffer write is suppressed.
- Reset (including mid-MB):
  - All outputs go to 0 immediately: `blk_valid`, `mb_busy`, `mb_done`, `blk_idx`, `topleft_x`, `topleft_y`, `nc`.
  - State goes to IDLE and `cur` is cleared.

## Timing
- nc and topleft are registered. They update on the ISSUE entry clock, at least one cycle before `blk_valid`.
- The counter loads on the cycle after `blk_valid`. First `cnt_valid` occurs 18 cycles after `blk_valid` (LOAD + 16 CNT + 1).
- The count is captured on the clock edge ending the first `cnt_valid` cycle. The next block's nc may depend on it and is ready before its issue.
- Minimum block period is 18 + encoder hold + 2 cycles.
- `mb_done` fires 1 cycle after the last WAIT_REL exit. A new `mb_start` is accepted on the cycle after `mb_done`.
- Simultaneous `cnt_valid` and `cnt_ready` cannot occur. If seen, `cnt_valid` takes priority.

## Configuration
- `CAVLC_SCHED_STAT_EN`:
  - Defined: adds outputs `nz_blk_cnt` (5b, number of blocks with count>0 in the last MB) and `mb_cycles` (16b, saturating cycles from `mb_start` to `mb_done`). Both update at `mb_done`; reset value 0.
  - Undefined: these ports and their counters are absent.

## Test plan
- MB (0,0), all counts 0 -> nc=0 for all 16 blocks; topleft sequence (0,0),(4,0),(0,4),(4,4),(8,0)…(12,12); one `mb_done`.
- MB (0,0), counter returns count=blk_idx -> block 3 nc=(1+2+1)>>1=2; block 1 nc=0 (nA=cur[0][0]=0, nB unavailable).
- Next MB (1,0) with the same counts -> block 0 nA=left[0]=5, nB unavailable -> nc=5.
- MB (1,1) after row 0 is done -> block 0 nc=(left[0]+top[4]+1)>>1 with expected values.
- `rst_n` low during block 7 WAIT_CNT -> all outputs 0 immediately; after release, `mb_start` restarts at blk_idx=0.
- `mb_start` pulsed while `mb_busy` -> ignored. With STAT_EN and 4 nonzero blocks -> `nz_blk_cnt`=4.
